// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: pixel coordinates plus the sync, enable and HDMI framing flags.
interface video_timing_gen_if;
  localparam int unsigned H_POS_W     = 12;
  localparam int unsigned V_POS_W     = 11;
  localparam int unsigned FRAME_CNT_W = 16;

  logic signed [H_POS_W-1:0] hPos;
  logic signed [V_POS_W-1:0] vPos;
  logic                      hsync;
  logic                      vsync;
  logic                      displayEnable;
  logic                      videoPreamble;
  logic                      videoGuard;
  logic                      frameStart;
  logic [FRAME_CNT_W-1:0]    frameCount;

  modport master (
    output hPos, vPos, hsync, vsync, displayEnable,
    output videoPreamble, videoGuard, frameStart, frameCount
  );

  modport slave (
    input hPos, vPos, hsync, vsync, displayEnable,
    input videoPreamble, videoGuard, frameStart, frameCount
  );
endinterface

// File: rtl/video_timing_gen.sv
// 720x480p60 raster timing generator: signed pixel coordinates and HDMI sync/framing flags,
// every output registered and aligned with the coordinates it describes.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE        = 720,
  parameter int unsigned H_FRONT         = 16,
  parameter int unsigned H_SYNC          = 62,
  parameter int unsigned H_BACK          = 60,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FRONT         = 9,
  parameter int unsigned V_SYNC          = 6,
  parameter int unsigned V_BACK          = 30,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic               pixelClock,
  input  logic               resetN,
  video_timing_gen_if.master timing
);

  localparam int unsigned HW = 12;
  localparam int unsigned VW = 11;
  localparam int unsigned FW = 16;

  localparam int HB = int'(H_FRONT + H_SYNC + H_BACK);
  localparam int VB = int'(V_FRONT + V_SYNC + V_BACK);

  localparam logic signed [HW-1:0] H_FIRST      = HW'(-HB);
  localparam logic signed [HW-1:0] H_LAST       = HW'(int'(H_ACTIVE) - 1);
  localparam logic signed [HW-1:0] H_STEP       = HW'(1);
  localparam logic signed [HW-1:0] H_SYNC_FIRST = HW'(int'(H_FRONT) - HB);
  localparam logic signed [HW-1:0] H_SYNC_LAST  = HW'(-int'(H_BACK) - 1);
  localparam logic signed [HW-1:0] H_PRE_FIRST  = HW'(-10);
  localparam logic signed [HW-1:0] H_PRE_LAST   = HW'(-3);
  localparam logic signed [HW-1:0] H_GRD_FIRST  = HW'(-2);
  localparam logic signed [HW-1:0] H_ZERO       = HW'(0);

  localparam logic signed [VW-1:0] V_FIRST      = VW'(-VB);
  localparam logic signed [VW-1:0] V_LAST       = VW'(int'(V_ACTIVE) - 1);
  localparam logic signed [VW-1:0] V_STEP       = VW'(1);
  localparam logic signed [VW-1:0] V_SYNC_FIRST = VW'(int'(V_FRONT) - VB);
  localparam logic signed [VW-1:0] V_SYNC_LAST  = VW'(-int'(V_BACK) - 1);
  localparam logic signed [VW-1:0] V_ZERO       = VW'(0);

  localparam logic SYNC_ON  = ~SYNC_ACTIVE_LOW;
  localparam logic SYNC_OFF = SYNC_ACTIVE_LOW;

  logic signed [HW-1:0] hPosQ;
  logic signed [VW-1:0] vPosQ;
  logic                 hsyncQ;
  logic                 vsyncQ;
  logic                 displayEnableQ;
  logic                 videoPreambleQ;
  logic                 videoGuardQ;
  logic                 frameStartQ;
  logic [FW-1:0]        frameCountQ;

  logic signed [HW-1:0] hNext;
  logic signed [VW-1:0] vNext;
  logic                 frameWrap;
  logic                 hInSync;
  logic                 vInSync;
  logic                 hActive;
  logic                 vActive;
  logic                 hInPreamble;
  logic                 hInGuard;

  // Next raster position; >= keeps the counters inside their ranges even from a corrupt state.
  always_comb begin
    hNext     = hPosQ + H_STEP;
    vNext     = vPosQ;
    frameWrap = 1'b0;
    if (hPosQ >= H_LAST) begin
      hNext = H_FIRST;
      if (vPosQ >= V_LAST) begin
        vNext     = V_FIRST;
        frameWrap = 1'b1;
      end else begin
        vNext = vPosQ + V_STEP;
      end
    end
  end

  // Flags are decoded from the next position so that, once registered, they line up with hPos/vPos.
  always_comb begin
    hInSync     = (hNext >= H_SYNC_FIRST) && (hNext <= H_SYNC_LAST);
    vInSync     = (vNext >= V_SYNC_FIRST) && (vNext <= V_SYNC_LAST);
    hActive     = (hNext >= H_ZERO);
    vActive     = (vNext >= V_ZERO);
    hInPreamble = (hNext >= H_PRE_FIRST) && (hNext <= H_PRE_LAST);
    hInGuard    = (hNext >= H_GRD_FIRST) && (hNext < H_ZERO);
  end

  always_ff @(posedge pixelClock) begin
    if (!resetN) begin
      hPosQ          <= H_FIRST;
      vPosQ          <= V_FIRST;
      hsyncQ         <= SYNC_OFF;
      vsyncQ         <= SYNC_OFF;
      displayEnableQ <= 1'b0;
      videoPreambleQ <= 1'b0;
      videoGuardQ    <= 1'b0;
      frameStartQ    <= 1'b0;
      frameCountQ    <= '0;
    end else begin
      hPosQ          <= hNext;
      vPosQ          <= vNext;
      hsyncQ         <= hInSync ? SYNC_ON : SYNC_OFF;
      vsyncQ         <= vInSync ? SYNC_ON : SYNC_OFF;
      displayEnableQ <= hActive && vActive;
      videoPreambleQ <= hInPreamble && vActive;
      videoGuardQ    <= hInGuard && vActive;
      frameStartQ    <= frameWrap;
      if (frameWrap) begin
        frameCountQ <= frameCountQ + FW'(1);
      end
    end
  end

  assign timing.hPos          = hPosQ;
  assign timing.vPos          = vPosQ;
  assign timing.hsync         = hsyncQ;
  assign timing.vsync         = vsyncQ;
  assign timing.displayEnable = displayEnableQ;
  assign timing.videoPreamble = videoPreambleQ;
  assign timing.videoGuard    = videoGuardQ;
  assign timing.frameStart    = frameStartQ;
  assign timing.frameCount    = frameCountQ;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default 720x480 build plus a shrunken raster in both sync polarities,
// all checked against a cycle-index arithmetic model of the raster.
module tb_video_timing_gen;

  localparam int F_HA = 720, F_HF = 16, F_HS = 62, F_HB = 60;
  localparam int F_VA = 480, F_VF = 9, F_VS = 6, F_VB = 30;
  localparam int F_LINE = F_HA + F_HF + F_HS + F_HB;

  localparam int S_HA = 24, S_HF = 3, S_HS = 4, S_HB = 13;
  localparam int S_VA = 12, S_VF = 2, S_VS = 3, S_VB = 4;
  localparam int S_HBL = S_HF + S_HS + S_HB;
  localparam int S_VBL = S_VF + S_VS + S_VB;
  localparam int S_LINE = S_HA + S_HBL;
  localparam int S_FRAME = S_LINE * (S_VA + S_VBL);

  typedef struct packed {
    logic signed [11:0] h;
    logic signed [10:0] v;
    logic               hs;
    logic               vs;
    logic               de;
    logic               pre;
    logic               grd;
    logic               fs;
    logic [15:0]        fc;
  } exp_t;

  logic   pixelClock = 1'b0;
  logic   resetN = 1'b0;
  int     checks = 0;
  int     errors = 0;
  longint n = 0;
  exp_t   actFull, actSmall, actSmallPos, expV;

  video_timing_gen_if ifFull();
  video_timing_gen_if ifSmall();
  video_timing_gen_if ifSmallPos();

  video_timing_gen dutFull (.pixelClock(pixelClock), .resetN(resetN), .timing(ifFull));

  video_timing_gen #(
    .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .SYNC_ACTIVE_LOW(1'b1)
  ) dutSmall (.pixelClock(pixelClock), .resetN(resetN), .timing(ifSmall));

  video_timing_gen #(
    .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .SYNC_ACTIVE_LOW(1'b0)
  ) dutSmallPos (.pixelClock(pixelClock), .resetN(resetN), .timing(ifSmallPos));

  assign actFull = {ifFull.hPos, ifFull.vPos, ifFull.hsync, ifFull.vsync, ifFull.displayEnable,
                    ifFull.videoPreamble, ifFull.videoGuard, ifFull.frameStart, ifFull.frameCount};
  assign actSmall = {ifSmall.hPos, ifSmall.vPos, ifSmall.hsync, ifSmall.vsync, ifSmall.displayEnable,
                     ifSmall.videoPreamble, ifSmall.videoGuard, ifSmall.frameStart, ifSmall.frameCount};
  assign actSmallPos = {ifSmallPos.hPos, ifSmallPos.vPos, ifSmallPos.hsync, ifSmallPos.vsync,
                        ifSmallPos.displayEnable, ifSmallPos.videoPreamble, ifSmallPos.videoGuard,
                        ifSmallPos.frameStart, ifSmallPos.frameCount};

  always #5 pixelClock = ~pixelClock;

  // Expected outputs n cycles after reset release (n = 0 is the reset state).
  function automatic exp_t refModel(input longint cyc, input int ha, input int hf, input int hs,
                                    input int hb, input int va, input int vf, input int vs,
                                    input int vb, input bit low);
    exp_t   r;
    int     hbl, vbl, h, v;
    longint lineLen, frameLen;
    hbl      = hf + hs + hb;
    vbl      = vf + vs + vb;
    lineLen  = longint'(ha + hbl);
    frameLen = lineLen * longint'(va + vbl);
    h        = int'(cyc % lineLen) - hbl;
    v        = int'((cyc / lineLen) % longint'(va + vbl)) - vbl;
    r.h      = 12'(h);
    r.v      = 11'(v);
    r.hs     = ((h >= hf - hbl) && (h < -hb)) ? !low : low;
    r.vs     = ((v >= vf - vbl) && (v < -vb)) ? !low : low;
    r.de     = (h >= 0) && (v >= 0);
    r.pre    = (v >= 0) && (h >= -10) && (h <= -3);
    r.grd    = (v >= 0) && (h >= -2) && (h <= -1);
    r.fs     = (cyc > 0) && ((cyc % frameLen) == 0);
    r.fc     = 16'(cyc / frameLen);
    return r;
  endfunction

  function automatic exp_t refFull(input longint cyc);
    return refModel(cyc, F_HA, F_HF, F_HS, F_HB, F_VA, F_VF, F_VS, F_VB, 1'b1);
  endfunction

  function automatic exp_t refSmall(input longint cyc, input bit low);
    return refModel(cyc, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, low);
  endfunction

  task automatic step();
    logic r;
    r = resetN;
    @(posedge pixelClock);
    n = r ? n + 1 : 0;
    #1;
  endtask

  task automatic test_reset();
    int   hold;
    exp_t rst;
    hold   = 5 + int'($urandom_range(0, 3));
    rst    = {12'(-138), 11'(-45), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    resetN = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      checks++;
      if (actFull !== rst) begin
        errors++; $display("FAIL reset_full cycle=%0d got=%h want=%h", i, actFull, rst);
      end
      expV = refSmall(0, 1'b1);
      checks++;
      if (actSmall !== expV) begin
        errors++; $display("FAIL reset_small cycle=%0d got=%h want=%h", i, actSmall, expV);
      end
    end
    resetN = 1'b1;
    step();
    checks++;
    if (ifFull.hPos !== 12'(-137) || ifFull.vPos !== 11'(-45)) begin
      errors++; $display("FAIL first_edge got=(%0d,%0d) want=(-137,-45)", ifFull.hPos, ifFull.vPos);
    end
    expV = refFull(n);
    checks++;
    if (actFull !== expV) begin
      errors++; $display("FAIL first_edge_model got=%h want=%h", actFull, expV);
    end
  endtask

  task automatic test_frame_wrap();
    int                 runLen = 0, maxRun = 0, vsCount = 0, pulses = 0;
    longint             firstN = -1, secondN = -1;
    logic [15:0]        fc1 = '0, fc2 = '0;
    logic signed [11:0] prevH;
    logic signed [10:0] prevV;
    prevH = ifSmall.hPos;
    prevV = ifSmall.vPos;
    for (int i = 0; i < 2 * S_FRAME + 5; i++) begin
      step();
      expV = refSmall(n, 1'b1);
      checks++;
      if (actSmall !== expV) begin
        errors++; $display("FAIL wrap_model n=%0d got=%h want=%h", n, actSmall, expV);
      end
      if (ifSmall.vsync === 1'b0) begin
        runLen++; vsCount++;
        if (runLen > maxRun) maxRun = runLen;
      end else begin
        runLen = 0;
      end
      if (prevH == 12'(S_HA - 1) && prevV == 11'(S_VA - 1)) begin
        checks++;
        if ({ifSmall.hPos, ifSmall.vPos, ifSmall.frameStart} !== {12'(-S_HBL), 11'(-S_VBL), 1'b1}) begin
          errors++;
          $display("FAIL wrap_transition got=(%0d,%0d,fs=%b) want=(%0d,%0d,fs=1)",
                   ifSmall.hPos, ifSmall.vPos, ifSmall.frameStart, -S_HBL, -S_VBL);
        end
      end
      if (ifSmall.frameStart === 1'b1) begin
        pulses++;
        if (pulses == 1) begin firstN = n; fc1 = ifSmall.frameCount; end
        else if (pulses == 2) begin secondN = n; fc2 = ifSmall.frameCount; end
      end
      prevH = ifSmall.hPos;
      prevV = ifSmall.vPos;
    end
    checks++;
    if (maxRun != S_VS * S_LINE) begin
      errors++; $display("FAIL vsync_run got=%0d want=%0d", maxRun, S_VS * S_LINE);
    end
    checks++;
    if (vsCount != 2 * S_VS * S_LINE) begin
      errors++; $display("FAIL vsync_total got=%0d want=%0d", vsCount, 2 * S_VS * S_LINE);
    end
    checks++;
    if (pulses != 2) begin
      errors++; $display("FAIL frame_pulses got=%0d want=2", pulses);
    end
    checks++;
    if (fc1 !== 16'd1 || fc2 !== 16'd2) begin
      errors++; $display("FAIL frame_count got=%0d,%0d want=1,2", fc1, fc2);
    end
    checks++;
    if (secondN - firstN != longint'(S_FRAME)) begin
      errors++; $display("FAIL frame_period got=%0d want=%0d", secondN - firstN, S_FRAME);
    end
  endtask

  task automatic test_polarity();
    exp_t inv;
    for (int i = 0; i < 3 * S_FRAME; i++) begin
      step();
      inv    = actSmall;
      inv.hs = ~inv.hs;
      inv.vs = ~inv.vs;
      checks++;
      if (actSmallPos !== inv) begin
        errors++; $display("FAIL polarity_pair n=%0d got=%h want=%h", n, actSmallPos, inv);
      end
      expV = refSmall(n, 1'b0);
      checks++;
      if (actSmallPos !== expV) begin
        errors++; $display("FAIL polarity_model n=%0d got=%h want=%h", n, actSmallPos, expV);
      end
    end
  endtask

  task automatic test_blank_line();
    int hsLow = 0, deC = 0, preC = 0, grdC = 0;
    for (int i = 0; i < 30000 && !(ifFull.vPos == 11'(-20) && ifFull.hPos == 12'(-138)); i++) begin
      step();
      expV = refFull(n);
      checks++;
      if (actFull !== expV) begin
        errors++; $display("FAIL blank_seek_model n=%0d got=%h want=%h", n, actFull, expV);
      end
    end
    checks++;
    if (!(ifFull.vPos == 11'(-20) && ifFull.hPos == 12'(-138))) begin
      errors++; $display("FAIL blank_seek timeout at (%0d,%0d) want (-138,-20)", ifFull.hPos, ifFull.vPos);
    end
    for (int i = 0; i < F_LINE; i++) begin
      if (ifFull.hsync === 1'b0) hsLow++;
      if (ifFull.displayEnable !== 1'b0) deC++;
      if (ifFull.videoPreamble !== 1'b0) preC++;
      if (ifFull.videoGuard !== 1'b0) grdC++;
      step();
      expV = refFull(n);
      checks++;
      if (actFull !== expV) begin
        errors++; $display("FAIL blank_line_model n=%0d got=%h want=%h", n, actFull, expV);
      end
    end
    checks++;
    if (hsLow != F_HS) begin
      errors++; $display("FAIL blank_hsync got=%0d want=%0d", hsLow, F_HS);
    end
    checks++;
    if (deC != 0 || preC != 0 || grdC != 0) begin
      errors++; $display("FAIL blank_flags got de=%0d pre=%0d grd=%0d want 0,0,0", deC, preC, grdC);
    end
    checks++;
    if (ifFull.hPos !== 12'(-138) || ifFull.vPos !== 11'(-19)) begin
      errors++; $display("FAIL blank_period got=(%0d,%0d) want=(-138,-19)", ifFull.hPos, ifFull.vPos);
    end
  endtask

  task automatic test_line_timing();
    int hsLow = 0, hsFirst = 9999, hsLast = -9999;
    int preC = 0, preFirst = 9999, preLast = -9999;
    int grdC = 0, grdFirst = 9999;
    int deC = 0, deFirst = 9999, deLast = -9999;
    int h;
    for (int i = 0; i < 30000 && !(ifFull.vPos == 11'(10) && ifFull.hPos == 12'(-138)); i++) begin
      step();
      expV = refFull(n);
      checks++;
      if (actFull !== expV) begin
        errors++; $display("FAIL line_seek_model n=%0d got=%h want=%h", n, actFull, expV);
      end
    end
    checks++;
    if (!(ifFull.vPos == 11'(10) && ifFull.hPos == 12'(-138))) begin
      errors++; $display("FAIL line_seek timeout at (%0d,%0d) want (-138,10)", ifFull.hPos, ifFull.vPos);
    end
    for (int i = 0; i < F_LINE; i++) begin
      h = int'(ifFull.hPos);
      if (ifFull.hsync === 1'b0) begin
        hsLow++; if (h < hsFirst) hsFirst = h; if (h > hsLast) hsLast = h;
      end
      if (ifFull.videoPreamble === 1'b1) begin
        preC++; if (h < preFirst) preFirst = h; if (h > preLast) preLast = h;
      end
      if (ifFull.videoGuard === 1'b1) begin
        grdC++; if (h < grdFirst) grdFirst = h;
      end
      if (ifFull.displayEnable === 1'b1) begin
        deC++; if (h < deFirst) deFirst = h; if (h > deLast) deLast = h;
      end
      step();
      expV = refFull(n);
      checks++;
      if (actFull !== expV) begin
        errors++; $display("FAIL line_model n=%0d got=%h want=%h", n, actFull, expV);
      end
    end
    checks++;
    if (hsLow != 62 || hsFirst != -122 || hsLast != -61) begin
      errors++; $display("FAIL line_hsync got cnt=%0d %0d..%0d want cnt=62 -122..-61", hsLow, hsFirst, hsLast);
    end
    checks++;
    if (preC != 8 || preFirst != -10 || preLast != -3) begin
      errors++; $display("FAIL line_preamble got cnt=%0d %0d..%0d want cnt=8 -10..-3", preC, preFirst, preLast);
    end
    checks++;
    if (grdC != 2 || grdFirst != -2) begin
      errors++; $display("FAIL line_guard got cnt=%0d first=%0d want cnt=2 first=-2", grdC, grdFirst);
    end
    checks++;
    if (deC != 720 || deFirst != 0 || deLast != 719) begin
      errors++; $display("FAIL line_de got cnt=%0d %0d..%0d want cnt=720 0..719", deC, deFirst, deLast);
    end
    checks++;
    if (ifFull.hPos !== 12'(-138) || ifFull.vPos !== 11'(11)) begin
      errors++; $display("FAIL line_period got=(%0d,%0d) want=(-138,11)", ifFull.hPos, ifFull.vPos);
    end
  endtask

  task automatic test_reset_mid_frame();
    exp_t               rst;
    int                 hold, pulses = 0;
    longint             pulseN = -1;
    logic signed [11:0] rh;
    logic signed [10:0] rv;
    rst = {12'(-138), 11'(-45), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    for (int i = 0; i < 2000 && !(ifFull.vPos == 11'(11) && ifFull.hPos == 12'(300)); i++) begin
      step();
      expV = refFull(n);
      checks++;
      if (actFull !== expV) begin
        errors++; $display("FAIL mid_seek_model n=%0d got=%h want=%h", n, actFull, expV);
      end
    end
    checks++;
    if (ifFull.hPos !== 12'(300) || ifFull.vPos !== 11'(11) || ifFull.displayEnable !== 1'b1) begin
      errors++; $display("FAIL mid_seek got=(%0d,%0d,de=%b) want=(300,11,de=1)",
                         ifFull.hPos, ifFull.vPos, ifFull.displayEnable);
    end
    resetN = 1'b0;
    step();
    checks++;
    if (actFull !== rst) begin
      errors++; $display("FAIL mid_reset_full got=%h want=%h", actFull, rst);
    end
    resetN = 1'b1;
    step();
    // Second mid-frame reset, at a random active pixel of the small raster.
    rh = 12'(int'($urandom_range(0, S_HA - 1)));
    rv = 11'(int'($urandom_range(0, S_VA - 1)));
    for (int i = 0; i < 2 * S_FRAME && !(ifSmall.hPos == rh && ifSmall.vPos == rv); i++) begin
      step();
      expV = refSmall(n, 1'b1);
      checks++;
      if (actSmall !== expV) begin
        errors++; $display("FAIL mid_small_seek n=%0d got=%h want=%h", n, actSmall, expV);
      end
    end
    checks++;
    if (ifSmall.hPos !== rh || ifSmall.vPos !== rv || ifSmall.displayEnable !== 1'b1) begin
      errors++; $display("FAIL mid_small_pos got=(%0d,%0d,de=%b) want=(%0d,%0d,de=1)",
                         ifSmall.hPos, ifSmall.vPos, ifSmall.displayEnable, rh, rv);
    end
    hold   = 1 + int'($urandom_range(0, 2));
    resetN = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      expV = refSmall(0, 1'b1);
      checks++;
      if (actSmall !== expV) begin
        errors++; $display("FAIL mid_small_reset cycle=%0d got=%h want=%h", i, actSmall, expV);
      end
    end
    resetN = 1'b1;
    for (int i = 0; i < S_FRAME + 3; i++) begin
      step();
      expV = refSmall(n, 1'b1);
      checks++;
      if (actSmall !== expV) begin
        errors++; $display("FAIL mid_small_model n=%0d got=%h want=%h", n, actSmall, expV);
      end
      expV = refFull(n);
      checks++;
      if (actFull !== expV) begin
        errors++; $display("FAIL mid_full_model n=%0d got=%h want=%h", n, actFull, expV);
      end
      if (ifSmall.frameStart === 1'b1) begin
        pulses++;
        if (pulses == 1) pulseN = n;
      end
    end
    checks++;
    if (pulses != 1 || pulseN != longint'(S_FRAME)) begin
      errors++; $display("FAIL mid_first_pulse got cnt=%0d at n=%0d want cnt=1 at n=%0d", pulses, pulseN, S_FRAME);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired at n=%0d", n);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_wrap();
    test_polarity();
    test_blank_line();
    test_line_timing();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
